// File: rtl/centroid_update_sequencer.sv
// Purpose : walks centroids 0..7, divides accumulated sums by point count, strobes new means.
// Latency : CLR 1 + per centroid (LOAD 1 + DIV 7*22 + EMIT 1), empty centroid 2; 1250 cycles per full pass.
// Backpr. : none; the accumulator bank must hold steady while busy. Optional: ROUND_NEAREST_EN (round-half-up).
module centroid_update_sequencer #(
  parameter int centroid_num     = 8,
  parameter int coord_num        = 7,
  parameter int accum_cord_width = 22,
  parameter int cordinate_width  = 13,
  parameter int count_width      = 10,
  parameter int dataWidth        = coord_num * cordinate_width
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  output logic [2:0]                             accum_sel,
  input  logic [coord_num*accum_cord_width-1:0]  accum_sum,
  input  logic [count_width-1:0]                 accum_count,
  input  logic [dataWidth-1:0]                   old_centroid,
  output logic [dataWidth-1:0]                   new_centroid,
  output logic [2:0]                             cent_num,
  output logic                                   convergence_reg_en,
  output logic                                   convergence_reg_reset,
  output logic                                   busy,
  output logic                                   done
);

`ifdef ROUND_NEAREST_EN
  // One extra dividend bit absorbs the half-divisor bias added for rounding.
  localparam int DIV_W = accum_cord_width + 1;
`else
  localparam int DIV_W = accum_cord_width;
`endif

  localparam logic [2:0] LAST_IDX   = 3'(centroid_num - 1);
  localparam logic [2:0] LAST_COORD = 3'(coord_num - 1);
  localparam logic [4:0] LAST_BIT   = 5'(DIV_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD,
    DIV,
    EMIT,
    DONE
  } state_t;

  state_t                                state;
  logic [2:0]                            idx;
  logic [2:0]                            coord;
  logic [4:0]                            bitcnt;
  logic [coord_num*accum_cord_width-1:0] sum_sh;
  logic [count_width-1:0]                count_reg;
  logic [count_width-1:0]                rem;
  logic [DIV_W-1:0]                      q;

  logic [count_width:0]                  trial;
  logic                                  take;
  logic [DIV_W-1:0]                      q_next;
  logic [count_width-1:0]                rem_next;
  logic [cordinate_width-1:0]            coord_val;
  logic [DIV_W-1:0]                      first_div;
  logic [DIV_W-1:0]                      next_div;

  // The centroid index doubles as bank address and output tag.
  assign accum_sel = idx;
  assign cent_num  = idx;

  // Dividend for coordinate 0 comes straight off the bank; later ones come from the shifted copy.
`ifdef ROUND_NEAREST_EN
  assign first_div = {1'b0, accum_sum[accum_cord_width-1:0]} + DIV_W'(accum_count >> 1);
  assign next_div  = {1'b0, sum_sh[2*accum_cord_width-1:accum_cord_width]} + DIV_W'(count_reg >> 1);
`else
  assign first_div = accum_sum[accum_cord_width-1:0];
  assign next_div  = sum_sh[2*accum_cord_width-1:accum_cord_width];
`endif

  // One restoring-division step plus saturation of the finished quotient.
  always_comb begin
    trial     = {rem, q[DIV_W-1]};
    take      = (trial >= {1'b0, count_reg});
    q_next    = {q[DIV_W-2:0], take};
    // When the subtraction is taken the result is below the divisor, so the low bits suffice.
    rem_next  = take ? (trial[count_width-1:0] - count_reg) : trial[count_width-1:0];
    coord_val = (|q_next[DIV_W-1:cordinate_width]) ? {cordinate_width{1'b1}}
                                                   : q_next[cordinate_width-1:0];
  end

  // Sequencer FSM with registered strobes and the shared serial divider.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state                 <= IDLE;
      idx                   <= 3'd0;
      coord                 <= 3'd0;
      bitcnt                <= 5'd0;
      sum_sh                <= '0;
      count_reg             <= '0;
      rem                   <= '0;
      q                     <= '0;
      new_centroid          <= '0;
      convergence_reg_en    <= 1'b0;
      convergence_reg_reset <= 1'b1;
      busy                  <= 1'b0;
      done                  <= 1'b0;
    end else begin
      convergence_reg_en    <= 1'b0;
      convergence_reg_reset <= 1'b1;
      done                  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state                 <= CLR;
            busy                  <= 1'b1;
            idx                   <= 3'd0;
            convergence_reg_reset <= 1'b0;
          end
        end
        CLR: begin
          state <= LOAD;
        end
        LOAD: begin
          sum_sh    <= accum_sum;
          count_reg <= accum_count;
          if (accum_count == '0) begin
            // Empty cluster: keep the previous mean.
            new_centroid       <= old_centroid;
            convergence_reg_en <= 1'b1;
            state              <= EMIT;
          end else begin
            coord  <= 3'd0;
            bitcnt <= 5'd0;
            rem    <= '0;
            q      <= first_div;
            state  <= DIV;
          end
        end
        DIV: begin
          q      <= q_next;
          rem    <= rem_next;
          bitcnt <= bitcnt + 5'd1;
          if (bitcnt == LAST_BIT) begin
            new_centroid[coord*cordinate_width +: cordinate_width] <= coord_val;
            bitcnt <= 5'd0;
            rem    <= '0;
            if (coord == LAST_COORD) begin
              convergence_reg_en <= 1'b1;
              state              <= EMIT;
            end else begin
              coord  <= coord + 3'd1;
              q      <= next_div;
              sum_sh <= sum_sh >> accum_cord_width;
            end
          end
        end
        EMIT: begin
          if (idx == LAST_IDX) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= idx + 3'd1;
            state <= LOAD;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          idx   <= 3'd0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/centroid_update_sequencer.md
# centroid_update_sequencer

Drives the per-centroid new-means stream consumed by `convergence_check_block`. On `start` it walks centroids 0..7 and reads each centroid's accumulated coordinate sums and point count from the accumulator bank. It divides each coordinate serially to form the new centroid, then presents `new_centroid`/`cent_num` with a one-cycle `convergence_reg_en` strobe. It also clears the convergence counter at the start of every pass and reports pass completion to the controller.

## Interface
Parameters:
- `centroid_num`, 8, centroids per pass (index width 3)
- `coord_num`, 7, coordinates per point
- `accum_cord_width`, 22, width of one accumulated coordinate sum
- `cordinate_width`, 13, width of one centroid coordinate
- `count_width`, 10, width of point count
- `dataWidth`, 91, `coord_num*cordinate_width`

Ports:
- `clk`  in  1  single clock, all logic on posedge
- `rst_n`  in  1  synchronous, active-high reset: `rst_n==1` at posedge resets (port name kept per codebase)
- `start`  in  1  begin a pass; sampled only in IDLE
- `accum_sel`  out  3  centroid index addressing accumulator bank and old-centroid mux
- `accum_sum`  in  154  7×22 sums for `accum_sel`, coord k at bits [22k+21:22k], combinational read
- `accum_count`  in  10  point count for `accum_sel`
- `old_centroid`  in  91  current centroid for `accum_sel`
- `new_centroid`  out  91  computed centroid, coord k at bits [13k+12:13k]
- `cent_num`  out  3  index of `new_centroid`
- `convergence_reg_en`  out  1  one-cycle strobe: `new_centroid`/`cent_num` valid
- `convergence_reg_reset`  out  1  active-low clear to convergence counter
- `busy`  out  1  high from CLR through DONE inclusive
- `done`  out  1  one-cycle pulse at end of pass

## Operation
- FSM states: IDLE, CLR, LOAD, DIV, EMIT, DONE.
- IDLE: `start` → CLR. Otherwise stay.
- CLR: drive `convergence_reg_reset=0` for this cycle only. Set idx=0 and go to LOAD.
- LOAD: latch `accum_sum`, `accum_count`, `old_centroid` for `accum_sel`=idx.
  - count==0 → EMIT (empty cluster keeps old centroid).
  - otherwise coord=0 → DIV.
- DIV: one shared restoring divider of 22-bit dividend by 10-bit divisor, one quotient bit per cycle, 22 cycles per coordinate, coordinates 0..6 in order.
  - Each quotient is truncated and saturated: if quotient[21:13]≠0, the coordinate is 13'h1FFF, else quotient[12:0].
  - Each coordinate is written into the `new_centroid` holding register as it completes.
  - After coord 6 → EMIT.
- EMIT: `convergence_reg_en=1` for exactly one cycle.
  - idx<7: idx+1 → LOAD.
  - idx==7 → DONE.
- DONE: `done=1` for one cycle → IDLE.
- `cent_num` and `accum_sel` equal idx from LOAD through EMIT of that centroid and are stable during DIV. They are 0 in IDLE and CLR.
- `new_centroid` holds the last emitted value until overwritten by the next centroid's coordinates.
- All arithmetic is unsigned. Remainder is discarded.
- `start` outside IDLE is ignored, with no restart and no queueing.

## Timing
- Reset values: `new_centroid`=0, `cent_num`=0, `accum_sel`=0, `convergence_reg_en`=0, `convergence_reg_reset`=1, `busy`=0, `done`=0, state IDLE.
- Reset asserted in any state: at that posedge all outputs take reset values. Any in-progress pass is abandoned and no further strobes occur.
- Cycle counts, with `start` seen at edge 0:
  - CLR is cycle 1.
  - Non-empty centroid: LOAD 1 + DIV 154 + EMIT 1 = 156 cycles.
  - Empty centroid: LOAD 1 + EMIT 1 = 2 cycles.
  - Full pass, all non-empty: 1 + 8×156 + 1 = 1250 cycles. First EMIT is at cycle 157, `done` at cycle 1250.
- `start` held high across DONE→IDLE starts a new pass in the cycle after IDLE is re-entered.
- The accumulator bank must hold its contents stable while `busy`=1.

## Configuration
- `ROUND_NEAREST_EN` defined:
  - dividend becomes 23 bits, sum + (count>>1), giving round-half-up;
  - DIV takes 23 cycles per coordinate, so a non-empty centroid takes 163 cycles and a full pass 1306;
  - saturation check is on quotient[22:13].
- Not defined: truncating division, 22 cycles per coordinate, timing as above.

## Test plan
- All counts=1, every sum=100 → 8 strobes with `cent_num` 0..7, every coord=100. First strobe at cycle 157, `done` at cycle 1250, `convergence_reg_reset` low only in cycle 1.
- Centroid 2: sum 7 on all coords, count 2 → coords=3. With `ROUND_NEAREST_EN`, coords=4.
- Centroid 5 count=0, `old_centroid`=91'h1234 → emitted `new_centroid`=91'h1234, strobe 2 cycles after entering LOAD.
- Sum 22'h3FFFFF, count 1 → coord=13'h1FFF. Sum 22'h3FFFFF, count 1023 → coord=4100.
- `rst_n`=1 mid-DIV of centroid 3 → next cycle all outputs at reset values, no further `convergence_reg_en`, `done` never pulses.
- `start` pulsed while `busy` → ignored: exactly 8 strobes and one `done` for the pass.
